lsu_mem_ctrl: RTL and testbench

Load/store controller for the multi-cycle core. It sits between the execute stage and the DPI memory port. It accepts one load or store request at a time over a valid/ready handshake and drives the DPI data-side read/write signals with correctly timed enables. For loads it extracts the addressed bytes from the 64-bit doubleword returned by the DPI port and zero- or sign-extends them, then returns the result to writeback over a second valid/ready handshake.

---
 rtl/lsu_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller between execute and the DPI data port.
// Handles alignment checking, timed read/write enables and load byte extraction.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrEn,
  input  logic [63:0] iReqAddr,
  input  logic [63:0] iReqWrData,
  input  logic [1:0]  iReqSize,
  input  logic        iReqUnsigned,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [63:0] oRespData,
  output logic        oRespMisalign,
  output logic        oMemRdEn,
  output logic [63:0] oMemRdAddrLoad,
  input  logic [63:0] iMemRdDataLoad,
  output logic        oMemWrEn,
  output logic [63:0] oMemWrAddr,
  output logic [63:0] oMemWrData,
  output logic [7:0]  oMemWrLen
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [2:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        w_mis;

  logic        r_rd_en, r_wr_en, r_resp_valid, r_resp_mis;
  logic [63:0] r_rd_addr, r_wr_addr, r_wr_data, r_resp_data;
  logic [7:0]  r_wr_len;

  function automatic logic [63:0] mask_sz(input logic [63:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    mask_sz = {56'd0, d[7:0]};
      2'd1:    mask_sz = {48'd0, d[15:0]};
      2'd2:    mask_sz = {32'd0, d[31:0]};
      default: mask_sz = d;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] d, input logic [2:0] off,
                                          input logic [1:0] sz, input logic uns);
    logic [63:0] s;
    s = d >> {off, 3'b000};
    case (sz)
      2'd0:    extract = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    extract = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    extract = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: extract = s;
    endcase
  endfunction

  always_comb begin
    case (iReqSize)
      2'd0:    w_mis = 1'b0;
      2'd1:    w_mis = iReqAddr[0];
      2'd2:    w_mis = |iReqAddr[1:0];
      default: w_mis = |iReqAddr[2:0];
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (iReqValid) w_next = w_mis ? RESP : (iReqWrEn ? WRITE : READ);
      READ:  if (r_cnt == 4'd1) w_next = RESP;
      WRITE: w_next = RESP;
      RESP:  if (iRespReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory-side address/data only move on the edges where their enables move.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_cnt        <= '0;
      r_off        <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_len     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_mis   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (iReqValid) begin
          if (w_mis) begin
            r_resp_valid <= 1'b1;
            r_resp_mis   <= 1'b1;
            r_resp_data  <= '0;
          end else if (iReqWrEn) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= iReqAddr;
            r_wr_data <= mask_sz(iReqWrData, iReqSize);
            r_wr_len  <= 8'(1) << iReqSize;
          end else begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= {iReqAddr[63:3], 3'b000};
            r_cnt     <= 4'(MEM_LAT);
            r_off     <= iReqAddr[2:0];
            r_size    <= iReqSize;
            r_uns     <= iReqUnsigned;
          end
        end
        READ: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_resp_valid <= 1'b1;
            r_resp_mis   <= 1'b0;
            r_resp_data  <= extract(iMemRdDataLoad, r_off, r_size, r_uns);
          end
        end
        WRITE: begin
          r_wr_en      <= 1'b0;
          r_wr_addr    <= '0;
          r_wr_data    <= '0;
          r_wr_len     <= '0;
          r_resp_valid <= 1'b1;
          r_resp_mis   <= 1'b0;
          r_resp_data  <= '0;
        end
        RESP: if (iRespReady) begin
          r_resp_valid <= 1'b0;
          r_resp_mis   <= 1'b0;
          r_resp_data  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign oReqReady      = (r_state == IDLE);
  assign oRespValid     = r_resp_valid;
  assign oRespData      = r_resp_data;
  assign oRespMisalign  = r_resp_mis;
  assign oMemRdEn       = r_rd_en;
  assign oMemRdAddrLoad = r_rd_addr;
  assign oMemWrEn       = r_wr_en;
  assign oMemWrAddr     = r_wr_addr;
  assign oMemWrData     = r_wr_data;
  assign oMemWrLen      = r_wr_len;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected responses are queued at request
// time and compared when the response handshake completes.
module tb_lsu_mem_ctrl;
  localparam int LAT = 3;

  logic        iClock, iReset;
  logic        iReqValid, oReqReady, iReqWrEn, iReqUnsigned;
  logic [63:0] iReqAddr, iReqWrData;
  logic [1:0]  iReqSize;
  logic        oRespValid, iRespReady, oRespMisalign;
  logic [63:0] oRespData;
  logic        oMemRdEn, oMemWrEn;
  logic [63:0] oMemRdAddrLoad, iMemRdDataLoad, oMemWrAddr, oMemWrData;
  logic [7:0]  oMemWrLen;

  typedef struct packed { logic [63:0] data; logic mis; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  lsu_mem_ctrl #(.MEM_LAT(LAT)) u_dut (
    .iClock(iClock), .iReset(iReset),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrEn(iReqWrEn),
    .iReqAddr(iReqAddr), .iReqWrData(iReqWrData), .iReqSize(iReqSize),
    .iReqUnsigned(iReqUnsigned),
    .oRespValid(oRespValid), .iRespReady(iRespReady), .oRespData(oRespData),
    .oRespMisalign(oRespMisalign),
    .oMemRdEn(oMemRdEn), .oMemRdAddrLoad(oMemRdAddrLoad), .iMemRdDataLoad(iMemRdDataLoad),
    .oMemWrEn(oMemWrEn), .oMemWrAddr(oMemWrAddr), .oMemWrData(oMemWrData),
    .oMemWrLen(oMemWrLen)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  // Byte-wise little-endian gather, then extension.
  function automatic logic [63:0] ld_model(input logic [63:0] dw, input logic [63:0] addr,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(int'(addr[2:0]) + i) +: 8];
    if (!uns && sz != 2'd3 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic run_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] sz, input logic uns, input int hold, input string nm);
    logic mis;
    exp_t e;
    int cyc, rdc, wrc, lat;
    logic [63:0] sd, mw;
    logic sm;
    mis = (addr & ((64'd1 << sz) - 64'd1)) != 64'd0;
    e.mis  = mis;
    e.data = (mis || wr) ? 64'd0 : ld_model(iMemRdDataLoad, addr, sz, uns);
    q.push_back(e);
    lat = mis ? 0 : (wr ? 1 : LAT);
    mw  = (sz == 2'd3) ? wdata : (wdata & ((64'd1 << (8 << sz)) - 64'd1));

    @(negedge iClock);
    chk({nm, ".ready"}, 64'(oReqReady), 64'd1);
    iReqValid = 1'b1; iReqWrEn = wr; iReqAddr = addr; iReqWrData = wdata;
    iReqSize = sz; iReqUnsigned = uns;
    @(negedge iClock);
    // Scramble the request bus: the DUT must use its latched copy.
    iReqValid = 1'b0; iReqWrEn = ~wr; iReqAddr = {$urandom, $urandom};
    iReqWrData = {$urandom, $urandom}; iReqSize = 2'($urandom); iReqUnsigned = ~uns;
    cyc = 0; rdc = 0; wrc = 0;
    while (!oRespValid && cyc < 64) begin
      if (oMemRdEn) begin
        rdc++;
        chk({nm, ".rdaddr"}, oMemRdAddrLoad, addr & ~64'h7);
      end
      if (oMemWrEn) begin
        wrc++;
        chk({nm, ".wraddr"}, oMemWrAddr, addr);
        chk({nm, ".wrdata"}, oMemWrData, mw);
        chk({nm, ".wrlen"}, 64'(oMemWrLen), 64'(1 << sz));
      end
      @(negedge iClock);
      cyc++;
    end
    chk({nm, ".latency"}, 64'(cyc), 64'(lat));
    chk({nm, ".rd_cycles"}, 64'(rdc), 64'((!mis && !wr) ? LAT : 0));
    chk({nm, ".wr_cycles"}, 64'(wrc), 64'((!mis && wr) ? 1 : 0));
    chk({nm, ".mem_idle"}, {oMemRdEn, oMemWrEn, oMemRdAddrLoad | oMemWrAddr | oMemWrData},
        '0);
    sd = oRespData; sm = oRespMisalign;
    for (int h = 0; h < hold; h++) begin
      iReqValid = 1'b1; iReqWrEn = 1'b0; iReqAddr = {$urandom, $urandom};
      @(negedge iClock);
      chk({nm, ".bp_valid"}, 64'(oRespValid), 64'd1);
      chk({nm, ".bp_data"}, {oRespData}, sd);
      chk({nm, ".bp_mis"}, 64'(oRespMisalign), 64'(sm));
      chk({nm, ".bp_ready"}, 64'(oReqReady), 64'd0);
      chk({nm, ".bp_en"}, {62'd0, oMemRdEn, oMemWrEn}, 64'd0);
    end
    iReqValid = 1'b0; iRespReady = 1'b1;
    e = q.pop_front();
    chk({nm, ".data"}, oRespData, e.data);
    chk({nm, ".mis"}, 64'(oRespMisalign), 64'(e.mis));
    @(negedge iClock);
    iRespReady = 1'b0;
    chk({nm, ".valid_drop"}, 64'(oRespValid), 64'd0);
    chk({nm, ".ready_back"}, 64'(oReqReady), 64'd1);
  endtask

  initial begin
    logic seen;
    iReset = 1'b0; iReqValid = 1'b0; iReqWrEn = 1'b0; iReqAddr = '0; iReqWrData = '0;
    iReqSize = '0; iReqUnsigned = 1'b0; iRespReady = 1'b0;
    iMemRdDataLoad = 64'h1122_8344_5566_7788;
    #12;
    chk("rst.ready", 64'(oReqReady), 64'd1);
    chk("rst.outs", {oRespValid, oRespMisalign, oMemRdEn, oMemWrEn, oMemWrLen,
                     oRespData | oMemRdAddrLoad | oMemWrAddr | oMemWrData}, '0);
    @(negedge iClock);
    iReset = 1'b1;

    run_req(1'b0, 64'h8000_0005, 64'd0, 2'd0, 1'b0, 0, "ld_sb");
    run_req(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b1, 0, "ld_uh");
    run_req(1'b0, 64'h8000_0004, 64'd0, 2'd1, 1'b0, 0, "ld_sh");
    run_req(1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b0, 0, "ld_sw");
    run_req(1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b1, 0, "ld_d");
    run_req(1'b1, 64'h8000_0104, 64'hDEAD_BEEF_CAFE_F00D, 2'd2, 1'b0, 0, "st_w");
    run_req(1'b1, 64'h8000_0107, 64'hDEAD_BEEF_CAFE_F00D, 2'd0, 1'b0, 0, "st_b");
    run_req(1'b0, 64'h8000_0003, 64'd0, 2'd2, 1'b0, 0, "mis_ld");
    run_req(1'b1, 64'h8000_0002, 64'h1234, 2'd3, 1'b0, 0, "mis_st");
    run_req(1'b0, 64'h8000_0002, 64'd0, 2'd1, 1'b0, 5, "bp_ld");
    iMemRdDataLoad = 64'hF0E1_D2C3_B4A5_9687;
    for (int i = 0; i < 6; i++)
      run_req(1'b0, {32'h8000_0000, 29'($urandom), 3'b000} | 64'((i * 2) & 7), 64'd0,
              2'(i % 3), 1'(i / 3), 0, "ld_rand");

    // Reset in the middle of a load.
    @(negedge iClock);
    iReqValid = 1'b1; iReqWrEn = 1'b0; iReqAddr = 64'h8000_0010; iReqSize = 2'd3;
    @(negedge iClock);
    iReqValid = 1'b0;
    @(negedge iClock);
    chk("rst_mid.rden_before", 64'(oMemRdEn), 64'd1);
    #2 iReset = 1'b0;
    #1;
    chk("rst_mid.rden", 64'(oMemRdEn), 64'd0);
    chk("rst_mid.rdaddr", oMemRdAddrLoad, 64'd0);
    chk("rst_mid.ready", 64'(oReqReady), 64'd1);
    @(negedge iClock);
    iReset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge iClock);
      seen = seen | oRespValid | oMemRdEn;
    end
    chk("rst_mid.no_resp", 64'(seen), 64'd0);
    chk("sb.empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
